// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, visible flag, sync pulses and
// line/frame strobes, all registered and advanced by a pixel clock-enable.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pix_ce,
    output logic [9:0] o_pixel_x,
    output logic [9:0] o_pixel_y,
    output logic       o_visible_area,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    always_comb begin
        x_nxt = o_pixel_x + 10'd1;
        y_nxt = o_pixel_y;
        if (o_pixel_x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (o_pixel_y == Y_LAST) ? '0 : o_pixel_y + 10'd1;
        end
    end

    // Coordinate registers double as the counters; every decoded output is
    // computed from the next position so all outputs describe the same pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pixel_x      <= X_LAST;
            o_pixel_y      <= Y_LAST;
            o_visible_area <= 1'b0;
            o_hsync        <= !HSYNC_POL;
            o_vsync        <= !VSYNC_POL;
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            if (i_pix_ce) begin
                o_pixel_x      <= x_nxt;
                o_pixel_y      <= y_nxt;
                o_visible_area <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
                o_hsync        <= ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HSYNC_POL : !HSYNC_POL;
                o_vsync        <= ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VSYNC_POL : !VSYNC_POL;
                o_line_start   <= (x_nxt == '0);
                o_frame_start  <= (x_nxt == '0) && (y_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: a default 640x480 instance and a tiny
// raster instance (inverted polarities) run side by side against a pixel-index model.
module tb_vga_timing_gen;

    localparam int HA_V = 640, HA_F = 16, HA_S = 96, HA_B = 48;
    localparam int VA_V = 480, VA_F = 10, VA_S = 2,  VA_B = 33;
    localparam int HB_V = 8,   HB_F = 2,  HB_S = 3,  HB_B = 2;
    localparam int VB_V = 6,   VB_F = 2,  VB_S = 2,  VB_B = 1;
    localparam int HT_A = HA_V + HA_F + HA_S + HA_B;
    localparam int VT_A = VA_V + VA_F + VA_S + VA_B;
    localparam int HT_B = HB_V + HB_F + HB_S + HB_B;
    localparam int VT_B = VB_V + VB_F + VB_S + VB_B;
    localparam int FR_A = HT_A * VT_A;
    localparam int FR_B = HT_B * VT_B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [9:0] xa, ya, xb, yb;
    logic       vis_a, hs_a, vs_a, ls_a, fs_a;
    logic       vis_b, hs_b, vs_b, ls_b, fs_b;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .i_clk(clk), .i_reset(rst), .i_pix_ce(ce),
        .o_pixel_x(xa), .o_pixel_y(ya), .o_visible_area(vis_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_line_start(ls_a), .o_frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(HB_V), .H_FRONT(HB_F), .H_SYNC(HB_S), .H_BACK(HB_B),
        .V_VISIBLE(VB_V), .V_FRONT(VB_F), .V_SYNC(VB_S), .V_BACK(VB_B),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .i_pix_ce(ce),
        .o_pixel_x(xb), .o_pixel_y(yb), .o_visible_area(vis_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_line_start(ls_b), .o_frame_start(fs_b)
    );

    int checks = 0;
    int errors = 0;

    // Model state: linear pixel index within the frame plus expected strobes.
    int pa, pb;
    bit e_ls_a, e_fs_a, e_ls_b, e_fs_b;
    int ce_cnt_b;
    bit fs_seen_b;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_range(input int v, input int lo, input int len);
        return (v >= lo) && (v < lo + len);
    endfunction

    task automatic compare_a();
        int x, y;
        x = pa % HT_A;
        y = pa / HT_A;
        check("a_x", int'(xa), x);
        check("a_y", int'(ya), y);
        check("a_vis", int'(vis_a), int'((x < HA_V) && (y < VA_V)));
        check("a_hsync", int'(hs_a), in_range(x, HA_V + HA_F, HA_S) ? 0 : 1);
        check("a_vsync", int'(vs_a), in_range(y, VA_V + VA_F, VA_S) ? 0 : 1);
        check("a_line_start", int'(ls_a), int'(e_ls_a));
        check("a_frame_start", int'(fs_a), int'(e_fs_a));
    endtask

    task automatic compare_b();
        int x, y;
        x = pb % HT_B;
        y = pb / HT_B;
        check("b_x", int'(xb), x);
        check("b_y", int'(yb), y);
        check("b_vis", int'(vis_b), int'((x < HB_V) && (y < VB_V)));
        check("b_hsync", int'(hs_b), in_range(x, HB_V + HB_F, HB_S) ? 1 : 0);
        check("b_vsync", int'(vs_b), in_range(y, VB_V + VB_F, VB_S) ? 1 : 0);
        check("b_line_start", int'(ls_b), int'(e_ls_b));
        check("b_frame_start", int'(fs_b), int'(e_fs_b));
    endtask

    task automatic step(input bit r, input bit c);
        @(negedge clk);
        rst = r;
        ce  = c;
        @(posedge clk);
        #1;
        if (r) begin
            pa = FR_A - 1;
            pb = FR_B - 1;
            {e_ls_a, e_fs_a, e_ls_b, e_fs_b} = '0;
            fs_seen_b = 1'b0;
        end else if (c) begin
            pa = (pa + 1) % FR_A;
            pb = (pb + 1) % FR_B;
            e_ls_a = (pa % HT_A) == 0;
            e_fs_a = pa == 0;
            e_ls_b = (pb % HT_B) == 0;
            e_fs_b = pb == 0;
            ce_cnt_b++;
        end else begin
            {e_ls_a, e_fs_a, e_ls_b, e_fs_b} = '0;
        end
        compare_a();
        compare_b();
        if (!r && fs_b) begin
            if (fs_seen_b) check("b_frame_period", ce_cnt_b, FR_B);
            fs_seen_b = 1'b1;
            ce_cnt_b  = 0;
        end
    endtask

    initial begin
        pa = 0;
        pb = 0;
        ce_cnt_b = 0;
        fs_seen_b = 1'b0;

        // Reset dominates a high pixel enable.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("rst_x", int'(xa), 799);
        check("rst_y", int'(ya), 524);
        check("rst_hsync", int'(hs_a), 1);
        check("rst_vsync", int'(vs_a), 1);

        step(1'b0, 1'b1);
        check("first_x", int'(xa), 0);
        check("first_y", int'(ya), 0);
        check("first_vis", int'(vis_a), 1);
        check("first_fs", int'(fs_a), 1);
        check("first_ls", int'(ls_a), 1);
        step(1'b0, 1'b0);
        check("first_fs_clear", int'(fs_a), 0);

        for (int i = 0; i < 60; i++) step(1'b0, i[0]);
        for (int i = 0; i < 2000; i++) step(1'b0, ($urandom % 4) != 0);

        // Hold at x=320 for five idle clocks, then resume.
        begin
            int n = 0;
            while ((pa % HT_A) != 320 && n < 2000) begin
                step(1'b0, 1'b1);
                n++;
            end
            check("reach_x320", int'((pa % HT_A) == 320), 1);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            check("resume_x", int'(xa), 321);
        end

        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1);

        // Reset in the middle of both sync pulses on the small raster.
        begin
            int n = 0;
            while (pb != (HB_V + HB_F + VB_S - 1 + 1) + (VB_V + VB_F + 1) * HT_B && n < 500) begin
                step(1'b0, 1'b1);
                n++;
            end
            check("reach_sync", int'(hs_b && vs_b), 1);
            step(1'b1, 1'b1);
            check("midsync_x", int'(xb), HT_B - 1);
            check("midsync_y", int'(yb), VT_B - 1);
            check("midsync_hsync", int'(hs_b), 0);
            check("midsync_vsync", int'(vs_b), 0);
        end

        for (int i = 0; i < 1500; i++) step(($urandom % 128) == 0, ($urandom % 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
